// File: rtl/tt_sample_ingress_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tt_sample_ingress_pkg                                          |
// | Purpose  : Shared definitions for the sample ingress endpoint: byte-phase |
// |            encoding, fixed sample width and default sizing values.        |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
package tt_sample_ingress_pkg;

   // A sample is always exactly two bytes on the pins.
   localparam int c_DATA_WIDTH    = 16;
   localparam int c_NUM_UNITS_DEF = 4;
   localparam int c_TIMEOUT_DEF   = 64;

   // Which byte of the pair the next strobe edge delivers.
   typedef enum logic [0:0] {
      PHASE_MSB = 1'b0,
      PHASE_LSB = 1'b1
   } phase_e;

endpackage
`default_nettype wire

// File: rtl/tt_strobe_edge.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tt_strobe_edge                                                 |
// | Purpose  : Rising-edge detector for the byte write strobe, qualified by   |
// |            the tile enable. A strobe held high yields a single pulse.     |
// | Ports    : clk, rst_n (sync, active-low), ena, strobe -> rise (1 cycle)   |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tt_strobe_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic strobe,
   output logic rise
);

   logic r_strb_q;

   // The delayed copy tracks the pin even while disabled, so raising ena
   // with the strobe already high does not fabricate an edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_strb_q <= 1'b0;
      end else begin
         r_strb_q <= strobe;
      end
   end

   assign rise = ena & strobe & ~r_strb_q;

endmodule
`default_nettype wire

// File: rtl/tt_sample_ingress.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tt_sample_ingress                                              |
// | Purpose  : DUT-side endpoint of the byte-serial sample load / readback    |
// |            protocol. Assembles {MSB,LSB} samples from strobed bytes, deals|
// |            them round-robin to channels, offers them over valid/ready,    |
// |            and drives a registered per-channel readback byte.             |
// | Ports    : clk, rst_n (sync, active-low), ena, wr_strobe, data_byte,      |
// |            rd_sel, results_flat, sample_ready (in);                       |
// |            sample_data, sample_ch, sample_valid, frame_done, overrun,     |
// |            byte_phase, rd_data (out)                                      |
// | Config   : BYTE_TIMEOUT_EN - abandon a half-received sample after TIMEOUT |
// |            idle cycles in the LSB phase and flag overrun.                 |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tt_sample_ingress
   import tt_sample_ingress_pkg::*;
#(
   parameter int NUM_UNITS  = c_NUM_UNITS_DEF,
   parameter int DATA_WIDTH = c_DATA_WIDTH,
   parameter int CH_W       = $clog2(NUM_UNITS),
   parameter int TIMEOUT    = c_TIMEOUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic                    wr_strobe,
   input  logic [7:0]              data_byte,
   input  logic [CH_W-1:0]         rd_sel,
   input  logic [NUM_UNITS*8-1:0]  results_flat,
   output logic [DATA_WIDTH-1:0]   sample_data,
   output logic [CH_W-1:0]         sample_ch,
   output logic                    sample_valid,
   input  logic                    sample_ready,
   output logic                    frame_done,
   output logic                    overrun,
   output logic                    byte_phase,
   output logic [7:0]              rd_data
);

   localparam logic [CH_W-1:0] c_LAST_CH = CH_W'(NUM_UNITS - 1);

   phase_e                  r_phase;
   phase_e                  w_phase_nxt;
   logic                    w_edge;
   logic                    w_resync;
   logic                    w_complete;
   logic                    w_accept;
   logic [DATA_WIDTH-1:0]   w_sample;
   logic [7:0]              w_rd_byte;

   logic [7:0]              r_msb;
   logic [CH_W-1:0]         r_ptr;
   logic                    r_valid;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [CH_W-1:0]         r_ch;
   logic                    r_overrun;
   logic                    r_frame_done;
   logic [7:0]              r_rd_data;

   tt_strobe_edge u_strobe_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .strobe (wr_strobe),
      .rise   (w_edge)
   );

`ifdef BYTE_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT + 1);

   logic [c_TO_W-1:0] r_to_cnt;

   // Counts idle cycles spent waiting for the LSB; any edge restarts it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (w_edge || w_resync || (r_phase == PHASE_MSB)) begin
         r_to_cnt <= '0;
      end else if (ena) begin
         r_to_cnt <= r_to_cnt + c_TO_W'(1);
      end
   end

   // An LSB arriving on the very cycle of expiry still completes the sample.
   assign w_resync = ena & (r_phase == PHASE_LSB) & ~w_edge
                   & (r_to_cnt == c_TO_W'(TIMEOUT));
`else
   assign w_resync = 1'b0;
`endif

   // Byte-phase state machine
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_phase <= PHASE_MSB;
      end else begin
         r_phase <= w_phase_nxt;
      end
   end

   always_comb begin
      w_phase_nxt = r_phase;
      if (w_edge) begin
         w_phase_nxt = (r_phase == PHASE_MSB) ? PHASE_LSB : PHASE_MSB;
      end else if (w_resync) begin
         w_phase_nxt = PHASE_MSB;
      end
   end

   assign w_complete = w_edge & (r_phase == PHASE_LSB);
   assign w_accept   = ena & r_valid & sample_ready;
   assign w_sample   = {r_msb, data_byte};

   // Readback mux; selects beyond the last channel read as zero.
   always_comb begin
      w_rd_byte = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (rd_sel == CH_W'(i)) begin
            w_rd_byte = results_flat[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_msb        <= '0;
         r_ptr        <= '0;
         r_valid      <= 1'b0;
         r_data       <= '0;
         r_ch         <= '0;
         r_overrun    <= 1'b0;
         r_frame_done <= 1'b0;
         r_rd_data    <= '0;
      end else begin
         r_rd_data    <= w_rd_byte;
         r_frame_done <= w_accept & (r_ch == c_LAST_CH);

         if (w_edge && (r_phase == PHASE_MSB)) begin
            r_msb <= data_byte;
         end else if (w_resync) begin
            r_msb <= '0;
         end

         // The pointer advances even when the sample is dropped, so the
         // channel assignment of later samples stays aligned with the host.
         if (w_complete) begin
            r_ptr <= (r_ptr == c_LAST_CH) ? '0 : r_ptr + CH_W'(1);
         end

         // One-deep holding register: a sample leaving this cycle frees the
         // slot for one arriving this cycle.
         if (w_complete && (!r_valid || w_accept)) begin
            r_valid <= 1'b1;
            r_data  <= w_sample;
            r_ch    <= r_ptr;
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end

         if ((w_complete && r_valid && !w_accept) || w_resync) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign sample_data  = r_data;
   assign sample_ch    = r_ch;
   assign sample_valid = r_valid;
   assign frame_done   = r_frame_done;
   assign overrun      = r_overrun;
   assign byte_phase   = r_phase;
   assign rd_data      = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_tt_sample_ingress.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_tt_sample_ingress                                           |
// | Purpose  : Self-checking bench for tt_sample_ingress. Expected samples    |
// |            are queued as bytes are strobed and popped on acceptance.      |
// | Config   : honours BYTE_TIMEOUT_EN for the byte-timeout scenario.         |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_tt_sample_ingress;

   localparam int NU   = 4;
   localparam int CH_W = 2;
   localparam int TO   = 64;

   logic              clk;
   logic              rst_n;
   logic              ena;
   logic              wr_strobe;
   logic [7:0]        data_byte;
   logic [CH_W-1:0]   rd_sel;
   logic [NU*8-1:0]   results_flat;
   logic [15:0]       sample_data;
   logic [CH_W-1:0]   sample_ch;
   logic              sample_valid;
   logic              sample_ready;
   logic              frame_done;
   logic              overrun;
   logic              byte_phase;
   logic [7:0]        rd_data;

   int                checks;
   int                failures;
   int                acc_cnt;
   int                fd_cnt;
   logic [17:0]       exp_q[$];
   logic [17:0]       mon_e;
   logic [CH_W-1:0]   exp_ptr;

   tt_sample_ingress #(
      .NUM_UNITS  (NU),
      .DATA_WIDTH (16),
      .CH_W       (CH_W),
      .TIMEOUT    (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .wr_strobe    (wr_strobe),
      .data_byte    (data_byte),
      .rd_sel       (rd_sel),
      .results_flat (results_flat),
      .sample_data  (sample_data),
      .sample_ch    (sample_ch),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .frame_done   (frame_done),
      .overrun      (overrun),
      .byte_phase   (byte_phase),
      .rd_data      (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard side: every handshake must match the oldest expected sample.
   always @(negedge clk) begin
      if (rst_n && ena && sample_valid && sample_ready) begin
         acc_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL accept_unexpected: got ch=%0d data=%h, required no sample", sample_ch, sample_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({sample_ch, sample_data} !== mon_e) begin
               failures++;
               $display("FAIL sample: got ch=%0d data=%h, required ch=%0d data=%h",
                        sample_ch, sample_data, mon_e[17:16], mon_e[15:0]);
            end
         end
      end
      if (frame_done) fd_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      data_byte = b;
      wr_strobe = 1'b1;
      tick(1);
      wr_strobe = 1'b0;
      tick(1);
   endtask

   task automatic send_sample(input logic [15:0] d);
      send_byte(d[15:8]);
      exp_q.push_back({exp_ptr, d});
      exp_ptr = exp_ptr + 2'd1;
      send_byte(d[7:0]);
   endtask

   task automatic send_dropped(input logic [15:0] d);
      send_byte(d[15:8]);
      exp_ptr = exp_ptr + 2'd1;
      send_byte(d[7:0]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_at_reset: got %0d queued, required 0", exp_q.size());
      end
      exp_q.delete();
      exp_ptr = '0;
   endtask

   task automatic test_reset();
      results_flat = 32'hA5A5_A5A5;
      rst_n = 1'b0;
      tick(2);
      checks++;
      if ({sample_valid, frame_done, overrun, byte_phase} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got %b, required 0000", {sample_valid, frame_done, overrun, byte_phase});
      end
      checks++;
      if ({sample_ch, sample_data} !== 18'h0) begin
         failures++;
         $display("FAIL reset_sample: got %h, required 0", {sample_ch, sample_data});
      end
      checks++;
      if (rd_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_rd_data: got %h, required 00", rd_data);
      end
      rst_n = 1'b1;
      exp_ptr = '0;
      tick(1);
      checks++;
      if (rd_data !== 8'hA5) begin
         failures++;
         $display("FAIL post_reset_rd_data: got %h, required a5", rd_data);
      end
   endtask

   task automatic test_basic();
      int a0;
      a0 = acc_cnt;
      sample_ready = 1'b1;
      send_sample(16'h1234);
      tick(1);
      checks++;
      if (acc_cnt !== a0 + 1) begin
         failures++;
         $display("FAIL basic_accepts: got %0d, required %0d", acc_cnt - a0, 1);
      end
      checks++;
      if ({sample_valid, byte_phase} !== 2'b00) begin
         failures++;
         $display("FAIL basic_idle: got valid/phase=%b, required 00", {sample_valid, byte_phase});
      end
   endtask

   task automatic test_round_robin();
      int f0;
      do_reset();
      f0 = fd_cnt;
      for (int i = 1; i <= 4; i++) send_sample(16'(i));
      tick(1);
      checks++;
      if (fd_cnt !== f0 + 1) begin
         failures++;
         $display("FAIL frame_done_count: got %0d, required 1", fd_cnt - f0);
      end
      checks++;
      if (frame_done !== 1'b0) begin
         failures++;
         $display("FAIL frame_done_width: got %b, required 0", frame_done);
      end
      send_sample(16'h0005);
      tick(2);
      checks++;
      if (fd_cnt !== f0 + 1) begin
         failures++;
         $display("FAIL frame_done_ch0: got %0d, required 1", fd_cnt - f0);
      end
   endtask

   task automatic test_overrun();
      sample_ready = 1'b0;
      send_sample(16'hAAAA);
      send_dropped(16'hBBBB);
      tick(2);
      checks++;
      if ({sample_valid, overrun} !== 2'b11) begin
         failures++;
         $display("FAIL overrun_flags: got valid/overrun=%b, required 11", {sample_valid, overrun});
      end
      checks++;
      if (sample_data !== 16'hAAAA) begin
         failures++;
         $display("FAIL overrun_hold_data: got %h, required aaaa", sample_data);
      end
      sample_ready = 1'b1;
      tick(2);
      checks++;
      if (exp_q.size() != 0 || sample_valid !== 1'b0) begin
         failures++;
         $display("FAIL overrun_drain: got queued=%0d valid=%b, required 0 0", exp_q.size(), sample_valid);
      end
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_sticky: got %b, required 1", overrun);
      end
   endtask

   task automatic test_strobe_hold();
      data_byte = 8'h55;
      wr_strobe = 1'b1;
      tick(5);
      wr_strobe = 1'b0;
      tick(1);
      checks++;
      if ({byte_phase, sample_valid} !== 2'b10) begin
         failures++;
         $display("FAIL strobe_hold: got phase/valid=%b, required 10", {byte_phase, sample_valid});
      end
      ena = 1'b0;
      send_byte(8'h66);
      ena = 1'b1;
      checks++;
      if ({byte_phase, sample_valid} !== 2'b10) begin
         failures++;
         $display("FAIL ena_gating: got phase/valid=%b, required 10", {byte_phase, sample_valid});
      end
      exp_q.push_back({exp_ptr, 16'h5577});
      exp_ptr = exp_ptr + 2'd1;
      send_byte(8'h77);
      tick(1);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL strobe_hold_complete: got %0d queued, required 0", exp_q.size());
      end
   endtask

   task automatic test_readback();
      results_flat = 32'h4433_2211;
      rd_sel = 2'd2;
      tick(1);
      checks++;
      if (rd_data !== 8'h33) begin
         failures++;
         $display("FAIL readback_ch2: got %h, required 33", rd_data);
      end
      rd_sel = 2'd3;
      tick(1);
      checks++;
      if (rd_data !== 8'h44) begin
         failures++;
         $display("FAIL readback_ch3: got %h, required 44", rd_data);
      end
      ena = 1'b0;
      rd_sel = 2'd1;
      tick(1);
      ena = 1'b1;
      checks++;
      if (rd_data !== 8'h22) begin
         failures++;
         $display("FAIL readback_no_ena: got %h, required 22", rd_data);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      send_byte(8'h9A);
      checks++;
      if (byte_phase !== 1'b1) begin
         failures++;
         $display("FAIL timeout_msb_phase: got %b, required 1", byte_phase);
      end
      tick(TO + 4);
`ifdef BYTE_TIMEOUT_EN
      checks++;
      if ({byte_phase, overrun} !== 2'b01) begin
         failures++;
         $display("FAIL timeout_resync: got phase/overrun=%b, required 01", {byte_phase, overrun});
      end
      send_sample(16'h0007);
`else
      checks++;
      if ({byte_phase, overrun} !== 2'b10) begin
         failures++;
         $display("FAIL timeout_wait: got phase/overrun=%b, required 10", {byte_phase, overrun});
      end
      exp_q.push_back({exp_ptr, 16'h9A00});
      exp_ptr = exp_ptr + 2'd1;
      send_byte(8'h00);
`endif
      tick(1);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL timeout_next_sample: got %0d queued, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      send_byte(8'hEE);
      checks++;
      if (byte_phase !== 1'b1) begin
         failures++;
         $display("FAIL mid_msb_phase: got %b, required 1", byte_phase);
      end
      do_reset();
      checks++;
      if (byte_phase !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_phase: got %b, required 0", byte_phase);
      end
      send_sample(16'h1357);
      tick(1);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL mid_reset_sample: got %0d queued, required 0", exp_q.size());
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      acc_cnt      = 0;
      fd_cnt       = 0;
      exp_ptr      = '0;
      rst_n        = 1'b0;
      ena          = 1'b1;
      wr_strobe    = 1'b0;
      data_byte    = 8'h00;
      rd_sel       = '0;
      results_flat = '0;
      sample_ready = 1'b1;

      test_reset();
      test_basic();
      test_round_robin();
      test_overrun();
      test_strobe_hold();
      test_readback();
      test_timeout();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
